// File: rtl/slow_mem_model_pkg.sv
// Shared definitions for the slow line-memory model: FSM states and bus widths.
package slow_mem_model_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/slow_mem_array.sv
// Line storage for the slow memory model: synchronous write, registered read.
// The array itself is never reset so hierarchically preloaded contents survive.
module slow_mem_array
    import slow_mem_model_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Array write port; no reset so contents persist across rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read data; holds until the next completed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/slow_mem_model.sv
// Fixed-latency line memory model: accepts one read or write at a time,
// completes it LATENCY edges after acceptance (acceptance edge included)
// and signals completion with a one-cycle mem_ready pulse.
module slow_mem_model
    import slow_mem_model_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               mem_ready_q;

    logic               req_held;
    logic               fire;
    logic               arr_we;
    logic               arr_re;

    // Upper address bits wrap away; they only feed this reduction.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];

    // Access strobes: the latched request must still be held at the final edge.
    always_comb begin
        req_held = is_write_q ? mem_write : mem_read;
        fire     = (state_q == BUSY) && req_held && (cnt_q == '0);
        arr_we   = fire && is_write_q;
        arr_re   = fire && !is_write_q;
    end

    // Request FSM: IDLE accepts, BUSY counts down (or aborts), DONE pulses ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_ready_q <= 1'b0;
                    if (mem_read || mem_write) begin
                        // Write wins when both requests arrive together.
                        is_write_q <= mem_write;
                        idx_q      <= mem_addr[IDX_W-1:0];
                        wdata_q    <= mem_wdata;
                        cnt_q      <= CNT_LOAD;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        mem_ready_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    mem_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    mem_ready_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    slow_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (arr_we),
        .rd_en (arr_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_slow_mem_model.sv
// Directed bench for slow_mem_model with LATENCY=10, DEPTH=256.
module tb_slow_mem_model;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] exp_mem [256];

    slow_mem_model #(
        .LATENCY (10),
        .DEPTH   (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] line_pat(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {32'hC0DE0000 + v, ~v, v * 32'd7, 32'h5A5A5A5A ^ v};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drives one request at a negedge, scrambles address/data after acceptance,
    // and returns the number of edges until mem_ready is seen (40 = timeout).
    task automatic do_access(input logic rd, input logic wr, input logic [27:0] addr,
                             input logic [127:0] wd, output int lat);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        @(negedge clk);
        lat = 1;
        mem_addr  = ~addr;
        mem_wdata = ~wd;
        while (!mem_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        $display("txn rd=%0b wr=%0b addr=%h wdata=%h lat=%0d rdata=%h",
                 rd, wr, addr, wd, lat, mem_rdata);
    endtask

    initial begin
        int           lat;
        logic [127:0] snap;
        logic         saw_ready;

        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = line_pat(i);
        end
        exp_mem[5] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        for (int i = 0; i < 256; i++) begin
            dut.u_array.mem[i] = exp_mem[i];
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);

        // Read of a preloaded line
        do_access(1'b1, 1'b0, 28'd5, '0, lat);
        check("rd5_latency", 128'(lat), 128'd10);
        check("rd5_data", mem_rdata, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        @(negedge clk);
        check("rd5_ready_one_cycle", 128'(mem_ready), 128'd0);

        // Write then read back; write must not disturb rdata
        snap = mem_rdata;
        do_access(1'b0, 1'b1, 28'd3, {16{8'hA5}}, lat);
        exp_mem[3] = {16{8'hA5}};
        check("wr3_latency", 128'(lat), 128'd10);
        check("wr3_rdata_unchanged", mem_rdata, snap);
        @(negedge clk);
        check("wr3_ready_one_cycle", 128'(mem_ready), 128'd0);
        do_access(1'b1, 1'b0, 28'd3, '0, lat);
        check("rd3_latency", 128'(lat), 128'd10);
        check("rd3_data", mem_rdata, {16{8'hA5}});
        @(negedge clk);

        // Read and write together is a write
        snap = mem_rdata;
        do_access(1'b1, 1'b1, 28'd7, 128'h1, lat);
        exp_mem[7] = 128'h1;
        check("rw7_latency", 128'(lat), 128'd10);
        check("rw7_rdata_unchanged", mem_rdata, snap);
        @(negedge clk);
        check("rw7_array", dut.u_array.mem[7], 128'h1);
        do_access(1'b1, 1'b0, 28'd7, '0, lat);
        check("rd7_data", mem_rdata, 128'h1);
        @(negedge clk);

        // Aborted write: mem_write dropped after 4 edges in flight
        mem_write = 1'b1;
        mem_addr  = 28'd9;
        mem_wdata = {4{32'hDEADBEEF}};
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ready = saw_ready | mem_ready;
        end
        mem_write = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw_ready = saw_ready | mem_ready;
        end
        $display("txn aborted write addr=9 ready_seen=%0b", saw_ready);
        check("wr9_abort_no_ready", 128'(saw_ready), 128'd0);
        check("wr9_array_kept", dut.u_array.mem[9], line_pat(9));
        do_access(1'b1, 1'b0, 28'd9, '0, lat);
        check("rd9_data", mem_rdata, line_pat(9));
        @(negedge clk);

        // Address wrap-around
        do_access(1'b1, 1'b0, 28'h100, '0, lat);
        check("rd100_latency", 128'(lat), 128'd10);
        check("rd100_wraps_to_0", mem_rdata, line_pat(0));
        @(negedge clk);

        // Reset in the middle of a read
        mem_read = 1'b1;
        mem_addr = 28'h11;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 128'(mem_ready), 128'd0);
        check("midrst_rdata", mem_rdata, 128'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset during read addr=11");
        check("midrst_array_3", dut.u_array.mem[3], {16{8'hA5}});
        check("midrst_array_5", dut.u_array.mem[5], exp_mem[5]);
        @(negedge clk);
        do_access(1'b1, 1'b0, 28'h11, '0, lat);
        check("post_rst_latency", 128'(lat), 128'd10);
        check("post_rst_data", mem_rdata, line_pat(17));
        @(negedge clk);
        check("post_rst_ready_one_cycle", 128'(mem_ready), 128'd0);
        do_access(1'b1, 1'b0, 28'd3, '0, lat);
        check("post_rst_rd3", mem_rdata, {16{8'hA5}});
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slow_mem_model.md
SLOW_MEM_MODEL -- requirements
Module: slow_mem_model

Interface
REQ-001 Parameter: LATENCY, default 10, clock edges from request acceptance to mem_ready (minimum 2).
REQ-002 Parameter: DEPTH, default 256, number of 128-bit lines in the storage array (power of two).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: mem_read  input  1  read request, held high until mem_ready.
REQ-006 Port: mem_write  input  1  write request, held high until mem_ready.
REQ-007 Port: mem_addr  input  28  line address (byte address bits 31:4).
REQ-008 Port: mem_wdata  input  128  write line data.
REQ-009 Port: mem_rdata  output  128  read line data, registered.
REQ-010 Port: mem_ready  output  1  one-cycle completion pulse, registered.

Function
REQ-011 The storage array SHALL be named mem, DEPTH entries of 128 bits, with entry i as line index i, so a bench can preload it hierarchically with binary line files.
REQ-012 Line index SHALL be mem_addr modulo DEPTH (low log2(DEPTH) bits); upper bits are ignored (wrap-around, no error).
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 In IDLE at a rising edge with mem_read or mem_write high, the block SHALL latch address, wdata and operation, load counter with LATENCY-2, and enter BUSY.
REQ-015 If mem_read and mem_write are both high at acceptance, the operation SHALL be a write.
REQ-016 In BUSY the counter SHALL decrement each edge; at an edge where the counter is 0, the latched operation SHALL be performed and the FSM SHALL enter DONE.
REQ-017 A write SHALL update mem[index] with the latched wdata at that edge; a read SHALL load mem_rdata from mem[index] at that edge.
REQ-018 mem_ready SHALL be high exactly while in DONE, i.e. for the single cycle following the edge LATENCY edges after acceptance.
REQ-019 From DONE the FSM SHALL return to IDLE unconditionally; a request still high there is accepted as a new request one edge later.
REQ-020 If, in BUSY, the latched request signal (mem_read for reads, mem_write for writes) is sampled low, the access SHALL abort: no array update, no mem_ready, return to IDLE.
REQ-021 Address and data changes during BUSY SHALL be ignored; latched values govern.
REQ-022 mem_rdata SHALL hold its value after a read until the next completed read; writes SHALL NOT change it.
REQ-023 A read of a line SHALL return the data of any write to it that completed earlier.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, counter 0, mem_ready 0 and mem_rdata 0, aborting any access in flight without an array update.
REQ-025 Reset SHALL NOT clear the storage array, so preloaded contents survive reset.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the line width (128) and the address width (28).
REQ-027 The storage array with its synchronous write and registered read SHALL be a separate sub-module named slow_mem_array; the FSM and counter stay in slow_mem_model.

Verification
REQ-028 Preload mem[5]=0x00112233_44556677_8899AABB_CCDDEEFF, hold read addr 5 -> mem_ready is high for exactly one cycle, 10 edges after acceptance, and mem_rdata equals the preloaded line.
REQ-029 Write addr 3 data 0xA5 repeated, then read addr 3 -> read returns the 0xA5 line, and mem_rdata is unchanged during the write.
REQ-030 Assert read and write together on addr 7 with data 0x1 -> treated as a write: mem[7]=0x1, mem_rdata unchanged.
REQ-031 Drop mem_write at cycle 4 of a write to addr 9 -> no mem_ready pulse and mem[9] retains its old value.
REQ-032 With DEPTH=256, read addr 0x100 -> returns mem[0].
REQ-033 Assert rst mid-read, then release -> mem_ready=0 and mem_rdata=0 immediately, array contents intact, and the next read completes with normal latency.
